subneg_mem_responder: RTL

- Memory-side end of the subneg CPU's multiplexed external bus.
- Emulates the address latch plus SRAM that the CPU drives through LE/MOE/MWE and the shared 8-bit address/data lines.
- Also implements the memory-mapped display register.
- Used as the on-die/FPGA memory for bring-up and as the bus-functional responder in CPU system benches. A side loader port preloads the program.

---
 rtl/subneg_pkg.sv | 23 ++
 rtl/subneg_mem_array.sv | 26 ++
 rtl/subneg_mem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/subneg_pkg.sv
// Shared definitions for the subneg external-bus memory responder.
// Includes pin indices, widths and the bus cycle classifier.
package subneg_pkg;
  localparam int DATA_W           = 8;
  localparam int ADDR_W           = 8;
  localparam int LE_BIT           = 0;
  localparam int MOE_BIT          = 1;
  localparam int MWE_BIT          = 2;
  localparam int DISPLAY_ADDR_DEF = 21;

  typedef enum logic [2:0] {IDLE, LATCH, READ, WRITE, CONFLICT} cyc_e;

  // le dominates; moe/mwe only matter when no address is being latched.
  function automatic cyc_e classify(input logic [2:0] ctl);
    if (ctl[LE_BIT]) return LATCH;
    case ({ctl[MWE_BIT], ctl[MOE_BIT]})
      2'b00:   return IDLE;
      2'b01:   return READ;
      2'b10:   return WRITE;
      default: return CONFLICT;
    endcase
  endfunction
endpackage

// File: rtl/subneg_mem_array.sv
// DEPTH x DATA_W flop array: one combinational read port, one synchronous
// write port, cleared synchronously on reset.
module subneg_mem_array
  import subneg_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (reset)     mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-power-of-two DEPTH leaves unused index codes; read them as zero.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/subneg_mem_responder.sv
// Memory side of the subneg multiplexed bus: address latch, SRAM,
// memory-mapped display register and sticky protocol error flag.
module subneg_mem_responder
  import subneg_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int DISPLAY_ADDR = DISPLAY_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              le,
  input  logic              moe,
  input  logic              mwe,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] display,
  output logic              display_stb,
  output logic              err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              stb_q, stb_d;
  logic              err_q, err_d;

  logic [2:0]        ctl;
  cyc_e              cyc;
  logic              in_mem, is_disp, ld_in;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always_comb begin
    ctl          = '0;
    ctl[LE_BIT]  = le;
    ctl[MOE_BIT] = moe;
    ctl[MWE_BIT] = mwe;
  end

  assign cyc     = classify(ctl);
  assign in_mem  = 32'(addr_q) < DEPTH;
  assign is_disp = addr_q == ADDR_W'(DISPLAY_ADDR);
  assign ld_in   = 32'(ld_addr) < DEPTH;

  // Display decode wins over the array when DISPLAY_ADDR falls inside DEPTH.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    if (cyc == READ) begin
      bus_oe = 1'b1;
      if (addr_valid_q) begin
        if (is_disp)     bus_out = display_q;
        else if (in_mem) bus_out = mem_rdata;
      end
    end
  end

  always_comb begin
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    display_d    = display_q;
    stb_d        = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = addr_q[AW-1:0];
    mem_wdata    = bus_in;

    if (cyc == LATCH) begin
      addr_d       = bus_in;
      addr_valid_d = 1'b1;
    end
    if (cyc == CONFLICT) err_d = 1'b1;
    if ((cyc == READ || cyc == WRITE) && (!addr_valid_q || (!in_mem && !is_disp)))
      err_d = 1'b1;

    // Loader owns the write port; a colliding bus write is lost and flagged.
    if (ld_we) begin
      if (cyc == WRITE) err_d = 1'b1;
      mem_we    = ld_in;
      mem_waddr = ld_addr[AW-1:0];
      mem_wdata = ld_data;
    end else if (cyc == WRITE && addr_valid_q) begin
      if (is_disp) begin
        display_d = bus_in;
        stb_d     = 1'b1;
      end else if (in_mem) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      display_q    <= '0;
      stb_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      display_q    <= display_d;
      stb_q        <= stb_d;
      err_q        <= err_d;
    end
  end

  subneg_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign display     = display_q;
  assign display_stb = stb_q;
  assign err         = err_q;
endmodule
